rggen_bus_access_sequencer: RTL and testbench
=============================================

Name: rggen_bus_access_sequencer

Overview:
Host-facing front stage of the register block. It accepts one bus request at a time, holds it stable and broadcasts it to every register's address decoder. It then collects the matching register's ready/status/read data and returns a single response to the host. It also generates the decode-error and timeout responses, which the per-register decoders cannot produce on their own.

Parameters:
ADDRESS_WIDTH, 8, byte-address width forwarded to decoders
BUS_WIDTH, 32, data width in bits (power of 2, >=8)
REGISTERS, 1, number of register slices on the broadcast bus
ERROR_STATUS, 1'b0, 1: unmatched access returns DECODE_ERROR; 0: returns OKAY
DEFAULT_READ_DATA, {BUS_WIDTH{1'b0}}, read data returned on unmatched access or timeout
TIMEOUT_CYCLES, 0, 0 disables timeout; N>0: abort after N busy cycles with SLAVE_ERROR

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_req_valid  input  1  host request valid
o_req_ready  output  1  request accepted when valid&ready
i_req_access  input  2  bit0=1 write, 0 read; bit1 forwarded unchanged
i_req_address  input  ADDRESS_WIDTH  byte address
i_req_write_data  input  BUS_WIDTH  write data
i_req_strobe  input  BUS_WIDTH/8  byte enables
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  host accepts response
o_rsp_status  output  2  00 OKAY, 01 EXOKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR
o_rsp_read_data  output  BUS_WIDTH  read data
o_register_valid  output  1  broadcast access strobe
o_register_access  output  2  latched access
o_register_address  output  ADDRESS_WIDTH  latched address
o_register_write_data  output  BUS_WIDTH  latched write data
o_register_strobe  output  BUS_WIDTH/8  latched strobe
i_register_active  input  REGISTERS  per-register decoder match
i_register_ready  input  REGISTERS  per-register completion
i_register_status  input  2*REGISTERS  per-register status, slice i at [2i+1:2i]
i_register_read_data  input  BUS_WIDTH*REGISTERS  per-register read data

Behaviour:
- Clock is i_clk; reset is i_rst, synchronous and active-high.
- FSM states: IDLE, BUSY, RESPONSE. Reset puts the FSM in IDLE.
- Reset values: o_req_ready=1, o_rsp_valid=0, o_register_valid=0, o_rsp_status=00, o_rsp_read_data=0, latched request fields=0, timeout counter=0.
- IDLE: o_req_ready=1. On i_req_valid, latch access/address/data/strobe and go to BUSY next cycle. o_req_ready is 0 in BUSY and RESPONSE.
- BUSY: o_register_valid=1 and the latched fields stay stable. Evaluated each cycle:
  - No bit of i_register_active set: go to RESPONSE. Status = ERROR_STATUS ? 11 : 00. Read data = DEFAULT_READ_DATA. This happens one cycle after entry; no register-ready wait.
  - Else, if any (active & ready) bit set: go to RESPONSE. Status and read data are the OR-reduction over slices gated by active & ready. Read data is captured for writes too; the host ignores it.
  - Else, if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1: go to RESPONSE with status 10 and DEFAULT_READ_DATA. o_register_valid drops the same cycle the state leaves BUSY.
  - The counter clears on BUSY entry and increments each BUSY cycle.
- Priority within one cycle: completion beats timeout. Multiple active slices is a configuration error and the OR result is accepted.
- RESPONSE: o_rsp_valid=1. Status and data are held registered until i_rsp_ready, then go to IDLE. Back-to-back latency is 1 IDLE + >=1 BUSY + >=1 RESPONSE cycle.
- Minimum latency from request acceptance to o_rsp_valid is 2 cycles.
- Reset mid-transaction aborts immediately: no response is issued and o_register_valid drops on the reset cycle's clock edge.
- i_rsp_ready held high while idle has no effect. A response is never dropped.

Decomposition:
- Shared package/header holds the access encoding (READ/WRITE bit index 0) and the status constants OKAY/EXOKAY/SLAVE_ERROR/DECODE_ERROR.
- The BUS_WIDTH-to-LSB computation reuses the common clog2 include.
- One sub-module: rggen_response_mux, a combinational gated OR-reduction of status/read data across REGISTERS, with an any_ready output.

Test Plan:
- Read of address 0x04 with slice1 active, ready after 2 busy cycles, data 0xA5A5_0001, status 00 -> o_rsp_valid 3 cycles after accept, data 0xA5A5_0001, status 00, o_register_valid high exactly 2 cycles.
- Write 0xDEAD_BEEF, strobe 4'b0011 -> o_register_write_data/strobe stable throughout BUSY; response status 00.
- Access to 0xF0 with no active slice, ERROR_STATUS=1, DEFAULT_READ_DATA=0x0 -> status 11 and data 0 two cycles after accept. Repeat with ERROR_STATUS=0 -> status 00.
- TIMEOUT_CYCLES=4, slice active but never ready -> status 10 after exactly 4 BUSY cycles. Repeat with ready asserted on cycle 4 -> status 00 from the register.
- i_rsp_ready held low 5 cycles -> o_rsp_valid/status/data stable and o_req_ready=0 throughout. A new request presented meanwhile is accepted only after the handshake.
- Assert i_rst during BUSY -> next cycle o_req_ready=1, o_register_valid=0, o_rsp_valid=0, with no response ever issued for the aborted request.

Source files
------------

// File: rtl/rggen_bus_access_sequencer_pkg.sv
// Shared encodings for the register-block host front stage.
// Access kind, response status, sequencer state and a clog2 helper.
package rggen_bus_access_sequencer_pkg;

    typedef enum logic {
        ACCESS_READ  = 1'b0,
        ACCESS_WRITE = 1'b1
    } access_e;

    typedef enum logic [1:0] {
        STATUS_OKAY         = 2'b00,
        STATUS_EXOKAY       = 2'b01,
        STATUS_SLAVE_ERROR  = 2'b10,
        STATUS_DECODE_ERROR = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_BUSY,
        STATE_RESPONSE
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rggen_response_mux.sv
// Gated OR-reduction of per-register status and read data.
// Only slices that are both active and ready contribute.
module rggen_response_mux #(
    parameter int BUS_WIDTH = 32,
    parameter int REGISTERS = 1
) (
    input  logic [REGISTERS-1:0]           i_active,
    input  logic [REGISTERS-1:0]           i_ready,
    input  logic [2*REGISTERS-1:0]         i_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_read_data,
    output logic                           o_any_ready,
    output logic [1:0]                     o_status,
    output logic [BUS_WIDTH-1:0]           o_read_data
);

    logic [REGISTERS-1:0] hit;

    assign hit         = i_active & i_ready;
    assign o_any_ready = |hit;

    always_comb begin
        o_status    = '0;
        o_read_data = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (hit[i]) begin
                o_status    = o_status | i_status[2*i+:2];
                o_read_data = o_read_data | i_read_data[BUS_WIDTH*i+:BUS_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rggen_bus_access_sequencer.sv
// Host front stage: holds one request, broadcasts it to the decoders,
// and returns a single response (including decode-error and timeout).
module rggen_bus_access_sequencer
    import rggen_bus_access_sequencer_pkg::*;
#(
    parameter int                  ADDRESS_WIDTH     = 8,
    parameter int                  BUS_WIDTH         = 32,
    parameter int                  REGISTERS         = 1,
    parameter bit                  ERROR_STATUS      = 1'b0,
    parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0,
    parameter int                  TIMEOUT_CYCLES    = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [1:0]                     i_req_access,
    input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
    input  logic [BUS_WIDTH-1:0]           i_req_write_data,
    input  logic [BUS_WIDTH/8-1:0]         i_req_strobe,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [1:0]                     o_rsp_status,
    output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
    output logic                           o_register_valid,
    output logic [1:0]                     o_register_access,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT =
        (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_e                 state;
    state_e                 state_next;
    logic [CW-1:0]          count;
    logic                   any_active;
    logic                   any_ready;
    logic                   timeout;
    logic                   finish;
    logic [1:0]             mux_status;
    logic [BUS_WIDTH-1:0]   mux_read_data;

    rggen_response_mux #(
        .BUS_WIDTH (BUS_WIDTH),
        .REGISTERS (REGISTERS)
    ) u_response_mux (
        .i_active    (i_register_active),
        .i_ready     (i_register_ready),
        .i_status    (i_register_status),
        .i_read_data (i_register_read_data),
        .o_any_ready (any_ready),
        .o_status    (mux_status),
        .o_read_data (mux_read_data)
    );

    assign any_active = |i_register_active;
    assign timeout    = (TIMEOUT_CYCLES > 0) && (count == LAST_COUNT);
    assign finish     = !any_active || any_ready || timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            STATE_IDLE:     if (i_req_valid) state_next = STATE_BUSY;
            STATE_BUSY:     if (finish) state_next = STATE_RESPONSE;
            STATE_RESPONSE: if (i_rsp_ready) state_next = STATE_IDLE;
            default:        state_next = STATE_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready      = 1'b0;
        o_register_valid = 1'b0;
        o_rsp_valid      = 1'b0;
        unique case (state)
            STATE_IDLE:     o_req_ready = 1'b1;
            STATE_BUSY:     o_register_valid = 1'b1;
            STATE_RESPONSE: o_rsp_valid = 1'b1;
            default:        o_req_ready = 1'b0;
        endcase
    end

    // Completion is checked before timeout so a late ready still wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_register_access     <= '0;
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
            o_rsp_status          <= '0;
            o_rsp_read_data       <= '0;
            count                 <= '0;
        end else begin
            if (state == STATE_IDLE && i_req_valid) begin
                o_register_access     <= i_req_access;
                o_register_address    <= i_req_address;
                o_register_write_data <= i_req_write_data;
                o_register_strobe     <= i_req_strobe;
                count                 <= '0;
            end
            if (state == STATE_BUSY) begin
                count <= count + 1'b1;
                if (!any_active) begin
                    o_rsp_status    <= ERROR_STATUS ? STATUS_DECODE_ERROR
                                                    : STATUS_OKAY;
                    o_rsp_read_data <= DEFAULT_READ_DATA;
                end else if (any_ready) begin
                    o_rsp_status    <= mux_status;
                    o_rsp_read_data <= mux_read_data;
                end else if (timeout) begin
                    o_rsp_status    <= STATUS_SLAVE_ERROR;
                    o_rsp_read_data <= DEFAULT_READ_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_rggen_bus_access_sequencer.sv
// Self-checking bench: directed plan steps plus randomized transactions
// checked against a cycle-count/response reference model.
module tb_rggen_bus_access_sequencer;

    localparam int TO = 4;
    localparam logic [31:0] B_DEFAULT = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_access;
    logic [7:0]  req_address;
    logic [31:0] req_write_data;
    logic [3:0]  req_strobe;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_read_data;
    logic        reg_valid;
    logic [1:0]  reg_access;
    logic [7:0]  reg_address;
    logic [31:0] reg_write_data;
    logic [3:0]  reg_strobe;
    logic [1:0]  reg_active;
    logic [1:0]  reg_ready;
    logic [3:0]  reg_status;
    logic [63:0] reg_read_data;

    logic        b_req_valid;
    logic        b_req_ready;
    logic        b_rsp_valid;
    logic [1:0]  b_rsp_status;
    logic [31:0] b_rsp_read_data;
    logic        b_reg_valid;
    logic [1:0]  b_reg_access;
    logic [7:0]  b_reg_address;
    logic [31:0] b_reg_write_data;
    logic [3:0]  b_reg_strobe;

    int compared = 0;
    int mismatched = 0;

    logic [1:0]  t_active;
    int          t_ready_at [2];
    logic [1:0]  t_status [2];
    logic [31:0] t_rdata [2];

    always #5 clk = ~clk;

    rggen_bus_access_sequencer #(
        .ADDRESS_WIDTH     (8),
        .BUS_WIDTH         (32),
        .REGISTERS         (2),
        .ERROR_STATUS      (1'b1),
        .DEFAULT_READ_DATA (32'h0),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_req_valid           (req_valid),
        .o_req_ready           (req_ready),
        .i_req_access          (req_access),
        .i_req_address         (req_address),
        .i_req_write_data      (req_write_data),
        .i_req_strobe          (req_strobe),
        .o_rsp_valid           (rsp_valid),
        .i_rsp_ready           (rsp_ready),
        .o_rsp_status          (rsp_status),
        .o_rsp_read_data       (rsp_read_data),
        .o_register_valid      (reg_valid),
        .o_register_access     (reg_access),
        .o_register_address    (reg_address),
        .o_register_write_data (reg_write_data),
        .o_register_strobe     (reg_strobe),
        .i_register_active     (reg_active),
        .i_register_ready      (reg_ready),
        .i_register_status     (reg_status),
        .i_register_read_data  (reg_read_data)
    );

    rggen_bus_access_sequencer #(
        .ADDRESS_WIDTH     (8),
        .BUS_WIDTH         (32),
        .REGISTERS         (1),
        .ERROR_STATUS      (1'b0),
        .DEFAULT_READ_DATA (B_DEFAULT),
        .TIMEOUT_CYCLES    (0)
    ) dut_b (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_req_valid           (b_req_valid),
        .o_req_ready           (b_req_ready),
        .i_req_access          (req_access),
        .i_req_address         (req_address),
        .i_req_write_data      (req_write_data),
        .i_req_strobe          (req_strobe),
        .o_rsp_valid           (b_rsp_valid),
        .i_rsp_ready           (1'b1),
        .o_rsp_status          (b_rsp_status),
        .o_rsp_read_data       (b_rsp_read_data),
        .o_register_valid      (b_reg_valid),
        .o_register_access     (b_reg_access),
        .o_register_address    (b_reg_address),
        .o_register_write_data (b_reg_write_data),
        .o_register_strobe     (b_reg_strobe),
        .i_register_active     (1'b0),
        .i_register_ready      (1'b0),
        .i_register_status     (2'b00),
        .i_register_read_data  (32'h0)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first busy cycle k (1..TO) in which an active slice is
    // ready completes; no active slice answers after one cycle.
    function automatic void model(output int busy, output logic [1:0] es,
                                  output logic [31:0] ed);
        busy = 0;
        es = 2'b00;
        ed = 32'h0;
        if (t_active == 2'b00) begin
            busy = 1;
            es = 2'b11;
            ed = 32'h0;
            return;
        end
        for (int k = 1; k <= TO; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (t_active[i] && t_ready_at[i] == k) begin
                    busy = k;
                    es = es | t_status[i];
                    ed = ed | t_rdata[i];
                end
            end
            if (busy != 0) return;
        end
        busy = TO;
        es = 2'b10;
        ed = 32'h0;
    endfunction

    task automatic drive_regs(input int k);
        reg_active = t_active;
        for (int i = 0; i < 2; i++) begin
            reg_ready[i] = t_active[i] && (k > 0) && (t_ready_at[i] == k);
        end
        reg_status = {t_status[1], t_status[0]};
        reg_read_data = {t_rdata[1], t_rdata[0]};
    endtask

    task automatic run_txn(input logic [1:0] acc, input logic [7:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb,
                           input int wait_cycles, input bit idle_ready);
        int busy;
        int exp_busy;
        logic [1:0] es;
        logic [31:0] ed;
        model(exp_busy, es, ed);
        drive_regs(0);
        req_access = acc;
        req_address = addr;
        req_write_data = wd;
        req_strobe = strb;
        req_valid = 1'b1;
        rsp_ready = idle_ready;
        chk("idle_req_ready", req_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        busy = 0;
        while (reg_valid === 1'b1 && busy < 20) begin
            busy++;
            req_access = 2'($urandom);
            req_address = 8'($urandom);
            req_write_data = $urandom;
            req_strobe = 4'($urandom);
            drive_regs(busy);
            chk("busy_access", reg_access, acc);
            chk("busy_address", reg_address, addr);
            chk("busy_wdata", reg_write_data, wd);
            chk("busy_strobe", reg_strobe, strb);
            chk("busy_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        reg_ready = 2'b00;
        chk("busy_cycles", busy, exp_busy);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_status", rsp_status, es);
        chk("rsp_data", rsp_read_data, ed);
        chk("rsp_req_ready", req_ready, 0);
        for (int w = 0; w < wait_cycles; w++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_status", rsp_status, es);
            chk("hold_data", rsp_read_data, ed);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_reg_valid", reg_valid, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("after_rsp_valid", rsp_valid, 0);
        chk("after_req_ready", req_ready, 1);
        chk("after_reg_valid", reg_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        b_req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_access = '0;
        req_address = '0;
        req_write_data = '0;
        req_strobe = '0;
        t_active = 2'b00;
        t_ready_at = '{0, 0};
        t_status = '{2'b00, 2'b00};
        t_rdata = '{32'h0, 32'h0};
        drive_regs(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_reg_valid", reg_valid, 0);
        chk("rst_status", rsp_status, 0);
        chk("rst_data", rsp_read_data, 0);
        chk("rst_address", reg_address, 0);
        chk("rst_wdata", reg_write_data, 0);
        chk("rst_strobe", reg_strobe, 0);
        chk("rst_access", reg_access, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Read, slice1 ready in its second busy cycle.
        t_active = 2'b10;
        t_ready_at = '{0, 2};
        t_status = '{2'b00, 2'b00};
        t_rdata = '{32'h1111_2222, 32'hA5A5_0001};
        run_txn(2'b00, 8'h04, 32'h0, 4'hF, 0, 1'b0);

        // Write with partial strobe.
        t_active = 2'b01;
        t_ready_at = '{1, 0};
        t_rdata = '{32'h0000_00AA, 32'h0};
        run_txn(2'b01, 8'h08, 32'hDEAD_BEEF, 4'b0011, 1, 1'b1);

        // Unmatched access -> decode error.
        t_active = 2'b00;
        t_rdata = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_txn(2'b00, 8'hF0, 32'h0, 4'hF, 0, 1'b0);

        // Never ready -> timeout; then ready exactly on the last cycle.
        t_active = 2'b01;
        t_ready_at = '{0, 0};
        t_status = '{2'b01, 2'b11};
        t_rdata = '{32'h1234_5678, 32'h0};
        run_txn(2'b00, 8'h10, 32'h0, 4'hF, 0, 1'b0);
        t_ready_at = '{TO, 0};
        t_status = '{2'b00, 2'b11};
        t_rdata = '{32'hCAFE_0004, 32'h0};
        run_txn(2'b00, 8'h10, 32'h0, 4'hF, 0, 1'b0);

        // Host stalls the response for five cycles.
        t_active = 2'b10;
        t_ready_at = '{0, 1};
        t_status = '{2'b00, 2'b01};
        t_rdata = '{32'h0, 32'h0BAD_F00D};
        run_txn(2'b10, 8'h0C, 32'h0, 4'hF, 5, 1'b0);

        // Unmatched access with error reporting disabled.
        req_address = 8'hF0;
        b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        chk("b_busy", b_reg_valid, 1);
        chk("b_busy_rsp", b_rsp_valid, 0);
        @(posedge clk); #1;
        chk("b_rsp_valid", b_rsp_valid, 1);
        chk("b_rsp_status", b_rsp_status, 2'b00);
        chk("b_rsp_data", b_rsp_read_data, B_DEFAULT);
        @(posedge clk); #1;
        chk("b_after_valid", b_rsp_valid, 0);
        chk("b_after_ready", b_req_ready, 1);

        // Reset while busy aborts without a response.
        t_active = 2'b01;
        t_ready_at = '{0, 0};
        drive_regs(0);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", reg_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_reg_valid", reg_valid, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b0;

        for (int n = 0; n < 40; n++) begin
            t_active = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                t_ready_at[i] = $urandom_range(0, 6);
                t_status[i] = 2'($urandom);
                t_rdata[i] = $urandom;
            end
            run_txn(2'($urandom), 8'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
